// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: recovers pixel x/y from hsync/vsync/active_video,
// measures line/frame/sync lengths against nominal values and reports lock.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_DISPLAY   = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_DISPLAY   = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        active_video,
  input  logic        clr_err,
  output logic        line_start,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [10:0] line_len,
  output logic [9:0]  frame_len,
  output logic [5:0]  err_flags,
  output logic        locked
);
  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] H_SYN  = 11'(H_SYNC);
  localparam logic [11:0] H_DISP = 12'(H_DISPLAY);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0]  V_SYN  = 10'(V_SYNC);
  localparam logic [10:0] V_DISP = 11'(V_DISPLAY);
  localparam logic [10:0] TO_LIM = 11'(2 * H_TOTAL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_s, vs_s, av_s, hs_prev, vs_line;
  logic [10:0] h_cnt, hw_cnt;
  logic [9:0]  v_cnt, vw_cnt;
  logic [4:0]  pend;
  logic [3:0]  ok_cnt;
  logic        seen_frame, timed_out, skip_len;

  logic        line_edge, hs_rise, frame_edge, vs_rise, timeout_hit, line_has_pix;
  logic [10:0] h_inc, hw_inc, pix_x_inc, act_lines;
  logic [9:0]  v_inc, vw_inc, pix_y_inc;
  logic [11:0] line_pix;
  logic [4:0]  new_pend, frame_chk;
  logic [3:0]  ok_inc;
  logic [5:0]  err_next;

  always_comb begin
    line_edge  = hs_prev & ~hs_s;
    hs_rise    = ~hs_prev & hs_s;
    frame_edge = line_edge & vs_line & ~vs_s;
    vs_rise    = line_edge & ~vs_line & vs_s;

    h_inc     = (h_cnt == '1) ? h_cnt : h_cnt + 11'd1;
    hw_inc    = (hw_cnt == '1) ? hw_cnt : hw_cnt + 11'd1;
    v_inc     = (v_cnt == '1) ? v_cnt : v_cnt + 10'd1;
    vw_inc    = (vw_cnt == '1) ? vw_cnt : vw_cnt + 10'd1;
    pix_x_inc = (pix_x == '1) ? pix_x : pix_x + 11'd1;
    pix_y_inc = (pix_y == '1) ? pix_y : pix_y + 10'd1;

    timeout_hit = ~line_edge & ~timed_out & (h_inc == TO_LIM);

    // pix_valid still holds the last pixel of the line that is ending now
    line_pix     = {1'b0, pix_x} + {11'd0, pix_valid};
    line_has_pix = (line_pix != 12'd0);
    act_lines    = {1'b0, pix_y} + {10'd0, line_has_pix};

    new_pend = '0;
    if (line_edge) begin
      new_pend[0] = ~timed_out & ~skip_len & (h_inc != H_TOT);
      new_pend[4] = line_has_pix & (line_pix != H_DISP);
    end
    if (hs_rise) new_pend[1] = (hw_cnt != H_SYN);
    if (vs_rise) new_pend[3] = (vw_cnt != V_SYN);

    frame_chk = pend | new_pend | {act_lines != V_DISP, 1'b0, v_inc != V_TOT, 2'b00};
    ok_inc    = (ok_cnt >= LOCK_N) ? LOCK_N : ok_cnt + 4'd1;

    err_next = clr_err ? 6'd0 : err_flags;
    if (frame_edge && seen_frame) err_next[4:0] = err_next[4:0] | frame_chk;
    if (timeout_hit) err_next[5] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s        <= 1'b1;
      vs_s        <= 1'b1;
      av_s        <= 1'b0;
      hs_prev     <= 1'b1;
      vs_line     <= 1'b1;
      h_cnt       <= '0;
      hw_cnt      <= '0;
      v_cnt       <= '0;
      vw_cnt      <= '0;
      pend        <= '0;
      ok_cnt      <= '0;
      seen_frame  <= 1'b0;
      timed_out   <= 1'b0;
      skip_len    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_len    <= '0;
      frame_len   <= '0;
      err_flags   <= '0;
      locked      <= 1'b0;
    end else begin
      hs_s        <= hsync;
      vs_s        <= vsync;
      av_s        <= active_video;
      hs_prev     <= hs_s;
      line_start  <= line_edge;
      frame_start <= frame_edge;
      pix_valid   <= av_s;
      err_flags   <= err_next;
      pend        <= frame_edge ? 5'd0 : (pend | new_pend);
      hw_cnt      <= line_edge ? 11'd1 : (~hs_s ? hw_inc : hw_cnt);

      if (line_edge) begin
        h_cnt     <= '0;
        line_len  <= h_inc;
        timed_out <= 1'b0;
        skip_len  <= timed_out;
        vs_line   <= vs_s;
        pix_x     <= '0;
        if (frame_edge) begin
          v_cnt     <= '0;
          frame_len <= v_inc;
          vw_cnt    <= 10'd1;
          pix_y     <= '0;
        end else begin
          v_cnt <= v_inc;
          if (!vs_s) vw_cnt <= vw_inc;
          if (line_has_pix) pix_y <= pix_y_inc;
        end
      end else begin
        // after a timeout h_cnt parks at the limit until hsync returns
        if (!timed_out) h_cnt <= h_inc;
        if (timeout_hit) timed_out <= 1'b1;
        if (pix_valid) pix_x <= pix_x_inc;
      end

      if (timeout_hit) begin
        locked     <= 1'b0;
        ok_cnt     <= '0;
        seen_frame <= 1'b0;
      end else if (frame_edge) begin
        if (!seen_frame) begin
          seen_frame <= 1'b1;
        end else if (frame_chk != 5'd0) begin
          ok_cnt <= '0;
          locked <= 1'b0;
        end else begin
          ok_cnt <= ok_inc;
          locked <= (ok_inc == LOCK_N);
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down timing generator
// (40 clk lines, 12-line frames) so several frames fit in a short run.
module tb_vga_timing_monitor;
  localparam int HT = 40, HS = 6, HA = 10, HD = 24;
  localparam int VT = 12, VS = 2, VA = 3, VD = 8;
  localparam int FRAME = HT * VT;
  localparam int WMAX = 2 * FRAME + 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        active_video = 1'b0;
  logic        clr_err = 1'b0;
  logic        line_start, frame_start, pix_valid, locked;
  logic [10:0] pix_x, line_len;
  logic [9:0]  pix_y, frame_len;
  logic [5:0]  err_flags;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_DISPLAY(HD),
    .V_TOTAL(VT), .V_SYNC(VS), .V_DISPLAY(VD), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .active_video(active_video), .clr_err(clr_err),
    .line_start(line_start), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .line_len(line_len), .frame_len(frame_len),
    .err_flags(err_flags), .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int gh, gv, last_h, last_v, obs_h, obs_v;
  int stretch_line = -1, short_hs_line = -1, nohs_first = -1, nohs_count = 0;
  bit short_vs = 1'b0;
  logic locked_before;

  task automatic gen_reset();
    gh = 0; gv = 0; last_h = -1; last_v = -1; obs_h = -1; obs_v = -1;
  endtask

  // Drive one generator position, advance one clock; obs_* is the position the
  // DUT outputs now describe (two clocks of latency).
  task automatic step();
    int  lt, hw, vw;
    bit  hs_off;
    lt     = (gv == stretch_line) ? HT + 1 : HT;
    hw     = (gv == short_hs_line) ? HS - 1 : HS;
    vw     = short_vs ? 1 : VS;
    hs_off = (nohs_count > 0) && (gv >= nohs_first) && (gv < nohs_first + nohs_count);
    hsync        = (gh >= hw) || hs_off;
    vsync        = (gv >= vw);
    active_video = (gv >= VA) && (gv < VA + VD) && (gh >= HA) && (gh < HA + HD);
    locked_before = locked;
    @(negedge clk);
    obs_h = last_h; obs_v = last_v;
    last_h = gh; last_v = gv;
    gh++;
    if (gh >= lt) begin
      gh = 0;
      gv++;
      if (gv >= VT) begin
        gv = 0;
        stretch_line = -1; short_hs_line = -1; short_vs = 1'b0; nohs_count = 0;
      end
    end
  endtask

  task automatic wait_frame(output bit got);
    got = 1'b0;
    for (int i = 0; i < WMAX && !got; i++) begin
      step();
      if (frame_start === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_line(input int want_v, output bit got);
    got = 1'b0;
    for (int i = 0; i < WMAX && !got; i++) begin
      step();
      if (line_start === 1'b1 && (want_v < 0 || obs_v == want_v)) got = 1'b1;
    end
  endtask

  function automatic bit act_line(input int v);
    return (v >= VA) && (v < VA + VD);
  endfunction

  function automatic int exp_px(input int h, input int v);
    if (!act_line(v) || h < HA) return 0;
    if (h < HA + HD) return h - HA;
    return HD;
  endfunction

  function automatic int exp_py(input int v);
    if (v <= VA) return 0;
    if (v >= VA + VD) return VD;
    return v - VA;
  endfunction

  task automatic pulse_clr(input string name);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (err_flags !== 6'd0) begin
      bad++; $display("FAIL %s_clr: err_flags=%b want 000000", name, err_flags);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; active_video = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({line_start, frame_start, pix_valid, locked} !== 4'b0000) begin
      bad++; $display("FAIL reset_bits: ls/fs/pv/lk=%b want 0000",
                      {line_start, frame_start, pix_valid, locked});
    end
    total++;
    if (pix_x !== 11'd0 || pix_y !== 10'd0) begin
      bad++; $display("FAIL reset_pix: x=%0d y=%0d want 0 0", pix_x, pix_y);
    end
    total++;
    if (line_len !== 11'd0 || frame_len !== 10'd0 || err_flags !== 6'd0) begin
      bad++; $display("FAIL reset_meas: line_len=%0d frame_len=%0d err=%b want 0 0 0",
                      line_len, frame_len, err_flags);
    end
    gen_reset();
    reset_n = 1'b1;
    step();
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL reset_fs_clk1: frame_start=%b want 0", frame_start);
    end
    step();
    total++;
    if (frame_start !== 1'b1 || line_start !== 1'b1) begin
      bad++; $display("FAIL reset_fs_clk2: fs=%b ls=%b want 1 1", frame_start, line_start);
    end
    $display("[tb] reset: checks=%0d bad=%0d", total, bad);
  endtask

  task automatic test_nominal();
    bit got;
    wait_frame(got);
    total++;
    if (!got) begin bad++; $display("FAIL nom_fs2: no frame_start, got 0 want 1"); end
    total++;
    if (line_len !== 11'(HT) || frame_len !== 10'(VT)) begin
      bad++; $display("FAIL nom_len: line_len=%0d frame_len=%0d want %0d %0d",
                      line_len, frame_len, HT, VT);
    end
    total++;
    if (locked !== 1'b0 || err_flags !== 6'd0) begin
      bad++; $display("FAIL nom_fs2_state: locked=%b err=%b want 0 000000", locked, err_flags);
    end
    wait_frame(got);
    total++;
    if (!got || locked !== 1'b1 || locked_before !== 1'b0) begin
      bad++; $display("FAIL nom_lock: got=%0d locked=%b before=%b want 1 1 0",
                      got, locked, locked_before);
    end
    total++;
    if (err_flags !== 6'd0) begin
      bad++; $display("FAIL nom_err: err=%b want 000000", err_flags);
    end
    $display("[tb] nominal: checks=%0d bad=%0d", total, bad);
  endtask

  task automatic test_pixels();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL pix_pre_lock: locked=%b want 1", locked); end
    for (int i = 0; i < FRAME; i++) begin
      step();
      total++;
      if (pix_valid !== (act_line(obs_v) && obs_h >= HA && obs_h < HA + HD) ||
          pix_x !== 11'(exp_px(obs_h, obs_v)) || pix_y !== 10'(exp_py(obs_v))) begin
        bad++; $display("FAIL pix_xy h=%0d v=%0d: pv=%b x=%0d y=%0d want x=%0d y=%0d",
                        obs_h, obs_v, pix_valid, pix_x, pix_y,
                        exp_px(obs_h, obs_v), exp_py(obs_v));
      end
      total++;
      if (line_start !== (obs_h == 0) || frame_start !== (obs_h == 0 && obs_v == 0)) begin
        bad++; $display("FAIL pix_pulses h=%0d v=%0d: ls=%b fs=%b", obs_h, obs_v,
                        line_start, frame_start);
      end
    end
    $display("[tb] pixels: checks=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stretch();
    bit got;
    stretch_line = 5;
    wait_frame(got);
    total++;
    if (!got || err_flags !== 6'b000001 || locked !== 1'b0) begin
      bad++; $display("FAIL stretch_err: got=%0d err=%b locked=%b want 1 000001 0",
                      got, err_flags, locked);
    end
    wait_frame(got);
    total++;
    if (!got || locked !== 1'b0) begin
      bad++; $display("FAIL stretch_relock1: got=%0d locked=%b want 1 0", got, locked);
    end
    wait_frame(got);
    total++;
    if (!got || locked !== 1'b1 || err_flags !== 6'b000001) begin
      bad++; $display("FAIL stretch_relock2: got=%0d locked=%b err=%b want 1 1 000001",
                      got, locked, err_flags);
    end
    pulse_clr("stretch");
    $display("[tb] stretch: checks=%0d bad=%0d", total, bad);
  endtask

  task automatic test_sync_short(input bit vert);
    bit got;
    logic [5:0] want;
    want = vert ? 6'b001000 : 6'b000010;
    wait_frame(got);
    if (vert) short_vs = 1'b1;
    else short_hs_line = 4;
    wait_frame(got);
    total++;
    if (!got || err_flags !== want || locked !== 1'b0) begin
      bad++; $display("FAIL sync_short_v%0d: got=%0d err=%b locked=%b want 1 %b 0",
                      vert, got, err_flags, locked, want);
    end
    pulse_clr(vert ? "vsync" : "hsync");
    wait_frame(got);
    total++;
    if (!got || locked !== 1'b0) begin
      bad++; $display("FAIL sync_relock1_v%0d: got=%0d locked=%b want 1 0", vert, got, locked);
    end
    wait_frame(got);
    total++;
    if (!got || locked !== 1'b1 || err_flags !== 6'd0) begin
      bad++; $display("FAIL sync_relock2_v%0d: got=%0d locked=%b err=%b want 1 1 000000",
                      vert, got, locked, err_flags);
    end
    $display("[tb] sync_short vert=%0d: checks=%0d bad=%0d", vert, total, bad);
  endtask

  task automatic test_timeout();
    bit got;
    nohs_first = 5;
    nohs_count = 2;
    wait_line(4, got);
    total++;
    if (!got) begin bad++; $display("FAIL to_line4: no line_start, got 0 want 1"); end
    repeat (2 * HT - 1) step();
    total++;
    if (err_flags[5] !== 1'b0 || locked !== 1'b1) begin
      bad++; $display("FAIL to_early: err5=%b locked=%b want 0 1", err_flags[5], locked);
    end
    step();
    total++;
    if (err_flags !== 6'b100000 || locked !== 1'b0) begin
      bad++; $display("FAIL to_hit: err=%b locked=%b want 100000 0", err_flags, locked);
    end
    wait_line(-1, got);
    total++;
    if (!got || obs_v != 7 || line_len !== 11'(2 * HT + 1)) begin
      bad++; $display("FAIL to_line_len: got=%0d v=%0d line_len=%0d want 1 7 %0d",
                      got, obs_v, line_len, 2 * HT + 1);
    end
    pulse_clr("timeout");
    for (int k = 0; k < 3; k++) begin
      wait_frame(got);
      total++;
      if (!got || locked !== (k == 2) || err_flags !== 6'd0) begin
        bad++; $display("FAIL to_relock%0d: got=%0d locked=%b err=%b want 1 %0d 000000",
                        k, got, locked, err_flags, (k == 2));
      end
    end
    $display("[tb] timeout: checks=%0d bad=%0d", total, bad);
  endtask

  task automatic test_mid_reset();
    repeat (100) step();
    total++;
    if (locked !== 1'b1 || frame_len !== 10'(VT)) begin
      bad++; $display("FAIL mr_pre: locked=%b frame_len=%0d want 1 %0d", locked, frame_len, VT);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (locked !== 1'b0 || line_len !== 11'd0 || frame_len !== 10'd0 ||
        pix_y !== 10'd0 || err_flags !== 6'd0) begin
      bad++; $display("FAIL mr_async: locked=%b line_len=%0d frame_len=%0d y=%0d err=%b want all 0",
                      locked, line_len, frame_len, pix_y, err_flags);
    end
    @(negedge clk);
    gen_reset();
    reset_n = 1'b1;
    step();
    step();
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL mr_restart: frame_start=%b want 1", frame_start);
    end
    $display("[tb] mid_reset: checks=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pixels();
    test_stretch();
    test_sync_short(1'b0);
    test_sync_short(1'b1);
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Sink-side checker and coordinate recoverer for the 640x480@60 VGA timing stream (hsync, vsync, active_video) produced by the display timing generator. It recovers per-pixel x/y coordinates for the downstream capture/compare path. It also measures line, frame and sync-pulse lengths against nominal values, raises sticky error flags and asserts a lock indication after consecutive clean frames. It sits on the same pixel clock as the generator, in loopback test builds or when taking external VGA timing.

Parameters:
H_TOTAL, 800, pixel clocks per line
H_SYNC, 96, hsync low width in clocks
H_DISPLAY, 640, active pixels per active line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync low width in lines
V_DISPLAY, 480, active lines per frame
LOCK_FRAMES, 2, consecutive clean frames required for lock (1..15)

Ports:
clk  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
hsync  input  1  horizontal sync, active low
vsync  input  1  vertical sync, active low
active_video  input  1  visible-pixel qualifier
clr_err  input  1  synchronous clear of err_flags
line_start  output  1  one-cycle pulse on detected hsync falling edge
frame_start  output  1  one-cycle pulse on detected frame edge
pix_valid  output  1  delayed active_video
pix_x  output  11  active-pixel index within line
pix_y  output  10  active-line index within frame
line_len  output  11  last measured line length in clocks
frame_len  output  10  last measured frame length in lines
err_flags  output  6  sticky: [0] line_len, [1] hsync width, [2] frame_len, [3] vsync width, [4] active geometry, [5] timeout
locked  output  1  timing locked

Behaviour:
- Reset: all outputs 0. Internal sampled hsync/vsync and their previous values reset to 1, so a low input at release counts as a falling edge. ok-frame counter = 0, seen_frame = 0.
- Stage 1 registers the inputs. Stage 2 does edge detection and counting. All outputs are registered, with 2 clk latency from input pins: line_start rises 2 clk after hsync falls, and pix_valid follows active_video by 2 clk.
- Line edge (sampled hsync 1->0):
  - line_len <= h_cnt+1, then h_cnt <= 0.
  - Otherwise h_cnt increments and saturates at 2047.
  - hsync width is counted while sampled hsync is low and checked on its rising edge.
  - Active pixel count per line must be 0 or H_DISPLAY.
- Vertical sync is sampled only on line edges. A frame edge is a sampled vsync 1->0 transition between consecutive line edges; it is coincident with a line edge.
- Frame edge:
  - frame_len <= v_cnt+1, then v_cnt <= 0.
  - Otherwise v_cnt increments on each line edge and saturates at 1023.
  - vsync width is counted in lines.
- pix_x: 0 at line edge, increments after each pix_valid cycle.
- pix_y: 0 at frame edge, increments at a line edge if the previous line contained any active pixel.
- Per-frame check at a frame edge, only when seen_frame=1. The frame is clean iff all of these hold:
  - every line_len == H_TOTAL except the first line following a timeout
  - every hsync width == H_SYNC
  - frame_len == V_TOTAL
  - vsync width == V_SYNC
  - active lines == V_DISPLAY
  - each active line has exactly H_DISPLAY pixels
- Each failing check sets its err_flags bit. Bits are sticky until clr_err. If clr_err and a new error occur in the same cycle, the new error wins.
- Lock:
  - A clean frame increments the ok counter, saturating at LOCK_FRAMES; locked=1 when the counter reaches LOCK_FRAMES.
  - Any failing frame clears the counter and locked in the same cycle that err_flags update.
  - The first frame edge after reset only sets seen_frame; no check is made.
- Timeout: if h_cnt reaches 2*H_TOTAL with no line edge, set err_flags[5], clear locked, the ok counter and seen_frame, and hold h_cnt saturated until the next line edge.
- Any reset_n assertion mid-frame returns the block to reset state immediately.

Test Plan:
1. Nominal stream from the timing generator released from reset together with the monitor:
   - frame_start at clk 2
   - line_len=800, frame_len=525
   - locked rises at the 3rd frame_start (~840000 clk later)
   - err_flags=0
2. During locked operation, scan each active line:
   - pix_x runs 0..639 with pix_valid=1, and pix_y runs 0..479 over the frame
   - after the 640th pixel, pix_valid=0 and pix_x=640
3. Stretch one line to 801 clk:
   - at the next frame edge err_flags[0]=1 and locked=0
   - relock after 2 further clean frames
4. Shorten hsync to 95 clk: err_flags[1]=1.
5. Shorten vsync to 1 line: err_flags[3]=1.
6. Hold hsync high for 1600 clk: err_flags[5]=1 and locked=0 at that cycle; pulse clr_err: err_flags=0.
